muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit beside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake and produces the 32-bit result after a fixed number of cycles.
- Parametrised in data width.
- Uses a 3-bit op encoding that extends the existing ALU-control enum style to M-extension funct3 values.

---
 rtl/muldiv_unit_pkg.sv | 51 +++++
 rtl/muldiv_unit_if.sv | 34 +++
 rtl/muldiv_unit_sign_fix.sv | 21 ++
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared types and helpers for the iterative RV32M multiply/
//               divide unit: op encoding (M-extension funct3), FSM states
//               and small op-decode functions.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam int DATA_BUS     = 32;
    localparam int MULDIV_WIDTH = 3;

    // funct3 values of the M extension
    typedef enum logic [MULDIV_WIDTH-1:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state;

    function automatic logic op_is_div(input muldiv_op op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input muldiv_op op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic op_b_signed(input muldiv_op op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle of the multiply/divide unit.
//               Request side : valid_i, ready_o, op_i, a_i, b_i, flush_i
//               Response side: valid_o, ready_i, result_o, busy_o
//               master = issuing stage, slave = muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = muldiv_unit_pkg::DATA_BUS
);
    logic                                   valid_i;
    logic                                   ready_o;
    logic [muldiv_unit_pkg::MULDIV_WIDTH-1:0] op_i;
    logic [DATA_WIDTH-1:0]                  a_i;
    logic [DATA_WIDTH-1:0]                  b_i;
    logic                                   flush_i;
    logic                                   valid_o;
    logic                                   ready_i;
    logic [DATA_WIDTH-1:0]                  result_o;
    logic                                   busy_o;

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Combinational conditional two's-complement negate. Used as an
//               absolute-value stage on operands (i_negate = signed & msb)
//               and as sign correction on results.
//               i_value  : input word
//               i_negate : negate when high
//               o_value  : i_value or -i_value
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);
    assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit, one result bit per
//               cycle. Multiply is shift-add on magnitudes, divide is
//               restoring division on magnitudes; signs are fixed up on the
//               final iteration.
//               clk   : rising-edge clock
//               rst_n : synchronous active-low reset
//               bus   : muldiv_unit_if.slave (request/response handshake)
//               Optional macro MULDIV_EARLY_OUT_EN: divide by zero, signed
//               overflow and multiply by zero finish one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int                   CNT_WIDTH  = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_load = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(1);

    if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 2) != 0)) begin : g_width_check
        $error("muldiv_unit: DATA_WIDTH must be even and >= 8");
    end

    muldiv_state                r_state, w_state_next;
    muldiv_op                   r_op, w_op_in;
    logic                       w_accept;
    logic                       w_a_neg, w_b_neg;
    logic [DATA_WIDTH-1:0]      w_a_mag, w_b_mag;
    logic [CNT_WIDTH-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0]      r_mcand;     // |b|: multiplicand or divisor
    logic [2*DATA_WIDTH-1:0]    r_prod;
    logic [DATA_WIDTH-1:0]      r_rem, r_quo;
    logic                       r_neg_prod, r_neg_quo, r_neg_rem;
    logic [DATA_WIDTH-1:0]      r_result;

    assign w_op_in  = muldiv_op'(bus.op_i);
    // A flush in IDLE blocks the accept for that cycle
    assign w_accept = bus.valid_i && (r_state == IDLE) && !bus.flush_i;
    assign w_a_neg  = op_a_signed(w_op_in) && bus.a_i[DATA_WIDTH-1];
    assign w_b_neg  = op_b_signed(w_op_in) && bus.b_i[DATA_WIDTH-1];

    muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_a (
        .i_value(bus.a_i), .i_negate(w_a_neg), .o_value(w_a_mag));
    muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_b (
        .i_value(bus.b_i), .i_negate(w_b_neg), .o_value(w_b_mag));

    // ---------------- one iteration of each algorithm ----------------------
    logic [DATA_WIDTH-1:0]   w_addend;
    logic [DATA_WIDTH:0]     w_sum;
    logic [2*DATA_WIDTH-1:0] w_prod_step;
    logic [DATA_WIDTH:0]     w_part, w_trial;
    logic [DATA_WIDTH-1:0]   w_rem_step, w_quo_step;

    // Multiplier sits in the low half and is consumed from the LSB while the
    // partial product (with carry) shifts down from the top.
    assign w_addend    = r_prod[0] ? r_mcand : '0;
    assign w_sum       = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, w_addend};
    assign w_prod_step = {w_sum, r_prod[DATA_WIDTH-1:1]};

    // Dividend shifts out of r_quo's MSB into the partial remainder while
    // quotient bits enter at the LSB; a borrow means restore.
    assign w_part     = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_trial    = w_part - {1'b0, r_mcand};
    assign w_rem_step = w_trial[DATA_WIDTH] ? w_part[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
    assign w_quo_step = {r_quo[DATA_WIDTH-2:0], ~w_trial[DATA_WIDTH]};

    // ---------------- sign correction on the final iteration ---------------
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quo_fix, w_rem_fix, w_final;

    muldiv_sign_fix #(.WIDTH(2*DATA_WIDTH)) u_fix_prod (
        .i_value(w_prod_step), .i_negate(r_neg_prod), .o_value(w_prod_fix));
    muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_quo (
        .i_value(w_quo_step), .i_negate(r_neg_quo), .o_value(w_quo_fix));
    muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_fix_rem (
        .i_value(w_rem_step), .i_negate(r_neg_rem), .o_value(w_rem_fix));

    always_comb begin
        w_final = w_quo_fix;
        case (r_op)
            MUL:                 w_final = w_prod_fix[DATA_WIDTH-1:0];
            MULH, MULHSU, MULHU: w_final = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            DIV, DIVU:           w_final = w_quo_fix;
            REM, REMU:           w_final = w_rem_fix;
            default:             w_final = w_quo_fix;
        endcase
    end

    // ---------------- special cases resolved at accept ---------------------
`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [DATA_WIDTH-1:0] c_most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic                  w_early;
    logic [DATA_WIDTH-1:0] w_early_result;

    always_comb begin
        w_early        = 1'b0;
        w_early_result = '0;
        if (op_is_div(w_op_in)) begin
            if (bus.b_i == '0) begin
                w_early        = 1'b1;
                w_early_result = op_is_rem(w_op_in) ? bus.a_i : '1;
            end else if (op_b_signed(w_op_in) && (bus.a_i == c_most_neg) && (bus.b_i == '1)) begin
                w_early        = 1'b1;
                w_early_result = op_is_rem(w_op_in) ? '0 : bus.a_i;
            end
        end else if ((bus.a_i == '0) || (bus.b_i == '0)) begin
            w_early = 1'b1;
        end
    end
`endif

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef MULDIV_EARLY_OUT_EN
                    w_state_next = w_early ? DONE : CALC;
`else
                    w_state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (bus.flush_i)              w_state_next = IDLE;
                else if (r_cnt == c_cnt_last) w_state_next = DONE;
            end
            DONE: begin
                if (bus.flush_i || bus.ready_i) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- datapath registers ------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= MUL;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg_prod <= 1'b0;
            r_neg_quo  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_op_in;
                        r_cnt      <= c_cnt_load;
                        r_mcand    <= w_b_mag;
                        r_prod     <= {{DATA_WIDTH{1'b0}}, w_a_mag};
                        r_rem      <= '0;
                        r_quo      <= w_a_mag;
                        r_neg_prod <= w_a_neg ^ w_b_neg;
                        // x/0 must give all ones whatever the dividend sign
                        r_neg_quo  <= (w_a_neg ^ w_b_neg) && (bus.b_i != '0);
                        r_neg_rem  <= w_a_neg;
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_early) r_result <= w_early_result;
`endif
                    end
                end
                CALC: begin
                    r_prod <= w_prod_step;
                    r_rem  <= w_rem_step;
                    r_quo  <= w_quo_step;
                    r_cnt  <= r_cnt - c_cnt_last;
                    if ((r_cnt == c_cnt_last) && !bus.flush_i) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = (r_state == IDLE);
    assign bus.valid_o  = (r_state == DONE);
    assign bus.busy_o   = (r_state != IDLE);
    assign bus.result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (32-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 1;
`else
    localparam int LAT_SPECIAL = 33;
`endif
    localparam int LAT_FULL = 33;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure cycles from accepting edge to valid_o, check result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic ready_low;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.a_i     = $urandom();
        bus.b_i     = $urandom();
        bus.op_i    = 3'($urandom_range(0, 7));
        lat         = 1;
        ready_low   = 1'b1;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            if (bus.ready_o !== 1'b0) ready_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.ready_o !== 1'b0) ready_low = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.result_o, exp_res);
        check({tag, "_rdy_low"}, 32'(ready_low), 32'd1);
        if (bus.ready_i === 1'b1) begin
            @(posedge clk); #1;
            check({tag, "_idle"}, 32'({bus.ready_o, bus.valid_o}), 32'b10);
        end
    endtask

    initial begin
        int   seen;
        logic stable;
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.op_i    = 3'b000;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_busy",  32'(bus.busy_o),  32'd0);
        check("rst_result", bus.result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // multiplies
        run_op("mul",    MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_FULL);
        run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL);
        run_op("mulh",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_FULL);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT_FULL);
        run_op("mul0",   MUL,    32'd0,        32'd12345,    32'h0000_0000, LAT_SPECIAL);

        // divides
        run_op("div",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_FULL);
        run_op("rem",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_FULL);
        run_op("divu", DIVU, 32'd100,       32'd7, 32'd14,        LAT_FULL);
        run_op("remu", REMU, 32'd100,       32'd7, 32'd2,         LAT_FULL);

        // divide by zero and signed overflow
        run_op("div_z",   DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPECIAL);
        run_op("rem_z",   REM, 32'd5,         32'd0,         32'd5,         LAT_SPECIAL);
        run_op("div_zn",  DIV, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, LAT_SPECIAL);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPECIAL);

        // backpressure: hold result for 10 cycles
        bus.ready_i = 1'b0;
        run_op("bp", DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd14) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({bus.ready_o, bus.valid_o}), 32'b10);

        // flush in IDLE blocks the accept
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = DIVU;
        bus.a_i     = 32'd50;
        bus.b_i     = 32'd5;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_idle_busy", 32'(bus.busy_o), 32'd0);

        // flush on the fifth CALC cycle
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = DIVU;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd3;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.valid_o !== 1'b0) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // reset mid-CALC
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = MUL;
        bus.a_i     = 32'd7;
        bus.b_i     = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", 32'(bus.ready_o), 32'd1);
        check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        check("mid_rst_busy",  32'(bus.busy_o),  32'd0);
        check("mid_rst_result", bus.result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_after", DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
